shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one 64-bit shift datapath (SLL/SRL/SRA plus RV64 word variants SLLW/SRLW/SRAW) between two requesters, e.g. the execute-stage ALU and the address/immediate unit.
- Arbitrates with round-robin priority, computes the shift, and holds a tagged result in a one-entry output register.
- The output register uses a valid/ready handshake with full backpressure.

Parameters:
- XLEN, 64, datapath width; only 64 is supported (the word ops use bit 31 and shamt[4:0]).
- RESET_LAST, 1, last-grant pointer value after reset; 1 gives req0 priority on the first contested cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- req0_valid  input  1  requester 0 has a shift request.
- req0_ready  output  1  request 0 is accepted on this edge.
- req0_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
- req0_word  input  1  1 selects the 32-bit W variant.
- req0_a  input  64  operand.
- req0_shamt  input  6  shift amount.
- req1_valid, req1_ready, req1_op, req1_word, req1_a, req1_shamt: same as requester 0.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes the result.
- out_y  output  64  shift result.
- out_id  output  1  requester index that owns out_y.

Behaviour:
- Reset (asynchronous, immediate on rst rising):
  - out_valid=0, out_y=0, out_id=0, last=RESET_LAST.
  - Both readies go 0 while rst is high; any in-flight result is discarded.
- State: the out_valid flag acts as a 2-state FSM.
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Grant (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last.
  - grant must not depend on out_ready except through the slot term below.
- Slot free: slot_free = !out_valid || out_ready.
- Ready: reqN_ready = !rst && slot_free && reqN_valid && (grant==N). At most one ready is high per cycle.
- Accept on edge with valid&&ready:
  - out_y <= shift(granted operands).
  - out_id <= N.
  - out_valid <= 1.
  - last <= N.
- Latency and throughput:
  - Latency is 1 cycle: the result is visible the cycle after acceptance.
  - Throughput is 1/cycle when out_ready stays high.
- Drain edge: out_valid && out_ready with no accept gives out_valid <= 0.
- Simultaneous drain and accept: the register reloads and out_valid stays 1.
- Backpressure: while out_valid && !out_ready, out_y and out_id hold exactly stable, and both readies are 0.
- Requester rules:
  - A requester must hold its valid and operands until ready.
  - The block does not latch unaccepted requests.
  - A request whose valid drops before grant is simply lost.
- 64-bit ops (word=0), s = shamt[5:0]:
  - SLL: a << s.
  - SRL: logical a >> s.
  - SRA: arithmetic, a[63] fills.
- Word ops (word=1), s = shamt[4:0] (shamt[5] ignored), w = a[31:0]:
  - SLLW: (w << s)[31:0].
  - SRLW: w >> s, zero-fill.
  - SRAW: arithmetic on w, w[31] fills.
  - Each 32-bit result is sign-extended from its bit 31 to 64 bits.
- Reserved op 10: result 0; the handshake completes normally.
- shamt=0: result is the operand, sign-extended to 64 bits for word ops.
- Round-robin fairness: with both requesters continuously valid and out_ready=1, grants alternate every cycle.

Test Plan:
- Single SRL: after reset, req0 SRL a=0x0123456789ABCDEF, shamt=4, out_ready=1.
  - req0_ready=1 in the request cycle.
  - Next cycle: out_valid=1, out_y=0x00123456789ABCDE, out_id=0.
- Contention: both valid from the first cycle after reset.
  - req0 SRA a=0x8000000000000000, shamt=63; req1 SLL a=1, shamt=63.
  - First result: out_y=0xFFFFFFFFFFFFFFFF, id=0.
  - Second result: out_y=0x8000000000000000, id=1.
  - A third req0 request is granted after req1 (alternation).
- Word ops:
  - SRAW a=0x0000000080000000, shamt=4 gives 0xFFFFFFFFF8000000.
  - SLLW a=0x0000000040000001, shamt=1 gives 0xFFFFFFFF80000002.
  - SRLW a=0x1234567880000000, shamt=36 (effective 4) gives 0x0000000008000000.
- Backpressure: hold out_ready=0 for 3 cycles with req1 valid.
  - out_y and out_id stay stable and req1_ready=0 throughout.
  - Raise out_ready: req1 is accepted on that same edge and the next result appears on the following cycle.
- Reset mid-operation: assert rst asynchronously while out_valid=1 between clock edges.
  - out_valid falls immediately and out_y=0.
  - After rst is released, req0 wins the first contested grant.
- Edge cases:
  - Reserved op 10 with a=0xFFFF gives out_y=0 with a normal handshake.
  - shamt=0 SLLW a=0x00000000FFFFFFFF gives 0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared RV64 shift unit.
// The shift result is held with its owner id in a one-entry valid/ready output register.
module shift_arbiter #(
    parameter int   XLEN       = 64,
    parameter logic RESET_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic            req0_word,
    input  logic [XLEN-1:0] req0_a,
    input  logic [5:0]      req0_shamt,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic            req1_word,
    input  logic [XLEN-1:0] req1_a,
    input  logic [5:0]      req1_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_y,
    output logic            out_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              last_r;
    logic              id_r;
    logic [XLEN-1:0]   y_r;
    logic              grant_s;
    logic              slot_free_s;
    logic              accept_s;
    logic [1:0]        op_s;
    logic              word_s;
    logic [XLEN-1:0]   a_s;
    logic [5:0]        shamt_s;
    logic [XLEN-1:0]   y_next_s;

    // Word variants shift a[31:0] by shamt[4:0] and sign-extend bit 31; op 2'b10 yields zero.
    function automatic logic [XLEN-1:0] shift_fn(input logic [1:0] op, input logic word,
                                                 input logic [XLEN-1:0] a, input logic [5:0] shamt);
        logic [31:0]     w;
        logic [31:0]     wr;
        logic [XLEN-1:0] r;
        w  = a[31:0];
        wr = 32'd0;
        r  = {XLEN{1'b0}};
        if (word) begin
            case (op)
                2'b00:   wr = w << shamt[4:0];
                2'b01:   wr = w >> shamt[4:0];
                2'b11:   wr = $signed(w) >>> shamt[4:0];
                default: wr = 32'd0;
            endcase
            r = {{(XLEN-32){wr[31]}}, wr};
        end else begin
            case (op)
                2'b00:   r = a << shamt;
                2'b01:   r = a >> shamt;
                2'b11:   r = $signed(a) >>> shamt;
                default: r = {XLEN{1'b0}};
            endcase
        end
        return r;
    endfunction

    // Round-robin grant: a contested cycle goes to the requester that did not win last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign slot_free_s = (state_r == EMPTY) || out_ready;
    assign req0_ready  = !rst && slot_free_s && req0_valid && (grant_s == 1'b0);
    assign req1_ready  = !rst && slot_free_s && req1_valid && (grant_s == 1'b1);
    assign accept_s    = req0_ready || req1_ready;

    // Steer the granted requester's operands into the shared shifter.
    always_comb begin
        op_s    = req0_op;
        word_s  = req0_word;
        a_s     = req0_a;
        shamt_s = req0_shamt;
        if (grant_s) begin
            op_s    = req1_op;
            word_s  = req1_word;
            a_s     = req1_a;
            shamt_s = req1_shamt;
        end else begin
            op_s    = req0_op;
            word_s  = req0_word;
            a_s     = req0_a;
            shamt_s = req0_shamt;
        end
    end

    assign y_next_s = shift_fn(op_s, word_s, a_s, shamt_s);

    // Output slot occupancy: an accept always refills, a drain without accept empties.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) state_next_s = FULL;
                else          state_next_s = EMPTY;
            end
            FULL: begin
                if (accept_s)       state_next_s = FULL;
                else if (out_ready) state_next_s = EMPTY;
                else                state_next_s = FULL;
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= EMPTY;
        else     state_r <= state_next_s;
    end

    // Result, owner and round-robin pointer load only on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r    <= {XLEN{1'b0}};
            id_r   <= 1'b0;
            last_r <= RESET_LAST;
        end else if (accept_s) begin
            y_r    <= y_next_s;
            id_r   <= grant_s;
            last_r <= grant_s;
        end
    end

    assign out_valid = (state_r == FULL);
    assign out_y     = y_r;
    assign out_id    = id_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus pushes expected {id,y} on accept,
// an independent monitor pops and compares on every output handshake.
module tb_shift_arbiter;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [5:0]  sh;
        logic [63:0] exp;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_word, req1_valid, req1_ready, req1_word;
    logic [1:0]  req0_op, req1_op;
    logic [63:0] req0_a, req1_a, out_y;
    logic [5:0]  req0_shamt, req1_shamt;
    logic        out_valid, out_ready, out_id;

    int checks = 0;
    int errors = 0;
    logic [64:0] sb[$];
    job_t q0[$];
    job_t q1[$];
    logic order[$];
    int stalls;

    shift_arbiter #(.XLEN(64), .RESET_LAST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_word(req0_word), .req0_a(req0_a), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_word(req1_word), .req1_a(req1_a), .req1_shamt(req1_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_id(out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got id=%0d y=%h expected none", out_id, out_y);
            end else begin
                chk("out", {out_id, out_y}, sb.pop_front());
            end
        end
    end

    function automatic job_t mk(input logic [1:0] op, input logic word, input logic [63:0] a,
                                input logic [5:0] sh, input logic [63:0] exp);
        job_t j;
        j.op = op; j.word = word; j.a = a; j.sh = sh; j.exp = exp;
        return j;
    endfunction

    task automatic apply();
        if (q0.size() > 0) begin
            req0_valid = 1'b1; req0_op = q0[0].op; req0_word = q0[0].word;
            req0_a = q0[0].a; req0_shamt = q0[0].sh;
        end else begin
            req0_valid = 1'b0;
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1; req1_op = q1[0].op; req1_word = q1[0].word;
            req1_a = q1[0].a; req1_shamt = q1[0].sh;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    // Present queued jobs, check grant order against 'order', push expected results.
    task automatic run_jobs(output int nstall);
        int guard;
        logic gid;
        guard  = 0;
        nstall = 0;
        apply();
        while ((q0.size() > 0 || q1.size() > 0) && guard < 50) begin
            @(negedge clk);
            guard++;
            if (req0_ready && req1_ready) begin
                chk("both_ready", 65'd1, 65'd0);
            end else if (req0_ready || req1_ready) begin
                gid = req1_ready;
                if (order.size() > 0) chk("grant", {64'd0, gid}, {64'd0, order.pop_front()});
                else chk("grant_extra", {64'd0, gid}, 65'h1_0000_0000_0000_0000);
                if (gid) sb.push_back({1'b1, q1.pop_front().exp});
                else     sb.push_back({1'b0, q0.pop_front().exp});
            end else begin
                nstall++;
            end
            @(posedge clk);
            #1;
            apply();
        end
        if (guard >= 50) begin
            chk("jobs_timeout", 65'd1, 65'd0);
            q0.delete(); q1.delete(); order.delete();
            apply();
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", {33'd0, sb.size()}, 65'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b00; req1_op = 2'b00; req0_word = 1'b0; req1_word = 1'b0;
        req0_a = 64'd0; req1_a = 64'd0; req0_shamt = 6'd0; req1_shamt = 6'd0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_out_y", {1'b0, out_y}, 65'd0);
        chk("rst_out_id", {64'd0, out_id}, 65'd0);
        chk("rst_ready", {63'd0, req1_ready, req0_ready}, 65'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single SRL, one-cycle latency
        q0.push_back(mk(2'b01, 1'b0, 64'h0123456789ABCDEF, 6'd4, 64'h00123456789ABCDE));
        order.push_back(1'b0);
        run_jobs(stalls);
        chk("srl_stall", {33'd0, stalls}, 65'd0);
        chk("lat_valid", {63'd0, out_valid, out_id}, 65'd2);
        wait_drain();

        // Contention from the first cycle after reset: 0, 1, 0
        do_reset();
        q0.push_back(mk(2'b11, 1'b0, 64'h8000000000000000, 6'd63, 64'hFFFFFFFFFFFFFFFF));
        q0.push_back(mk(2'b00, 1'b0, 64'h0000000000000001, 6'd4, 64'h0000000000000010));
        q1.push_back(mk(2'b00, 1'b0, 64'h0000000000000001, 6'd63, 64'h8000000000000000));
        order.push_back(1'b0); order.push_back(1'b1); order.push_back(1'b0);
        run_jobs(stalls);
        chk("contend_stall", {33'd0, stalls}, 65'd0);
        wait_drain();

        // Word ops; last grant was req0, so req1 goes first
        q0.push_back(mk(2'b11, 1'b1, 64'h0000000080000000, 6'd4, 64'hFFFFFFFFF8000000));
        q0.push_back(mk(2'b01, 1'b1, 64'h1234567880000000, 6'd36, 64'h0000000008000000));
        q1.push_back(mk(2'b00, 1'b1, 64'h0000000040000001, 6'd1, 64'hFFFFFFFF80000002));
        order.push_back(1'b1); order.push_back(1'b0); order.push_back(1'b0);
        run_jobs(stalls);
        wait_drain();

        // Edge cases: reserved op, shamt=0 word, shift by 63
        q1.push_back(mk(2'b10, 1'b0, 64'h000000000000FFFF, 6'd3, 64'h0000000000000000));
        q1.push_back(mk(2'b00, 1'b1, 64'h00000000FFFFFFFF, 6'd0, 64'hFFFFFFFFFFFFFFFF));
        q1.push_back(mk(2'b01, 1'b0, 64'h8000000000000000, 6'd63, 64'h0000000000000001));
        order.push_back(1'b1); order.push_back(1'b1); order.push_back(1'b1);
        run_jobs(stalls);
        wait_drain();

        // Backpressure: result held stable, req1 blocked for 3 cycles
        @(posedge clk);
        #1 out_ready = 1'b0;
        q0.push_back(mk(2'b01, 1'b0, 64'h0123456789ABCDEF, 6'd8, 64'h000123456789ABCD));
        order.push_back(1'b0);
        run_jobs(stalls);
        q1.push_back(mk(2'b00, 1'b0, 64'h000000000000000F, 6'd4, 64'h00000000000000F0));
        apply();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", {63'd0, req1_ready, out_valid}, 65'd1);
            chk("bp_hold", {out_id, out_y}, {1'b0, 64'h000123456789ABCD});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        order.push_back(1'b1);
        run_jobs(stalls);
        chk("bp_release_stall", {33'd0, stalls}, 65'd0);
        chk("bp_next", {63'd0, out_valid, out_id}, 65'd3);
        wait_drain();

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1 out_ready = 1'b0;
        q0.push_back(mk(2'b00, 1'b0, 64'h0000000000000001, 6'd1, 64'h0000000000000002));
        order.push_back(1'b0);
        run_jobs(stalls);
        req0_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid, out_id}, 65'd0);
        chk("arst_y", {1'b0, out_y}, 65'd0);
        chk("arst_ready", {64'd0, req0_ready}, 65'd0);
        sb.delete();
        req0_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        q0.push_back(mk(2'b01, 1'b0, 64'h00000000000000F0, 6'd4, 64'h000000000000000F));
        q1.push_back(mk(2'b11, 1'b0, 64'hF000000000000000, 6'd4, 64'hFF00000000000000));
        order.push_back(1'b0); order.push_back(1'b1);
        run_jobs(stalls);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
